forward_addr_cfg_ctrl: RTL and testbench

Sequential configuration controller for the `forward_selection_addr` address-forwarding mux of one dpsram_block_4x512x20 tile.
- Accepts new 8-bit forwarding configurations over a request/acknowledge handshake and rejects illegal ones.
- Freezes new RAM accesses, drains in-flight accesses, then applies the configuration atomically.
- Holds a settle window before releasing the RAM, so the cascaded address chain never switches mid-access.

---
 rtl/forward_addr_pkg.sv | 44 ++++
 rtl/forward_cfg_check.sv | 24 ++
 rtl/forward_addr_cfg_ctrl.sv | 147 ++++++++++++++
 tb/tb_forward_addr_cfg_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/forward_addr_pkg.sv
// Shared types, widths and config-byte field map for the forward_selection_addr
// configuration controller.
package forward_addr_pkg;

  localparam int unsigned CFG_W        = 8;
  localparam int unsigned DRAIN_CNT_W  = 8;
  localparam int unsigned SETTLE_CNT_W = 4;

  // Bit positions inside the mux config byte
  localparam int unsigned X0_SEL_LSB   = 0;
  localparam int unsigned X0_SEL_W     = 2;
  localparam int unsigned X1_SEL_LSB   = 2;
  localparam int unsigned X1_SEL_W     = 2;
  localparam int unsigned LOW_SEL_BIT  = 4;
  localparam int unsigned UP_SEL_BIT   = 5;
  localparam int unsigned X0_LOCAL_BIT = 6;
  localparam int unsigned X1_LOCAL_BIT = 7;

  // All ports on local addr1, no forwarding
  localparam logic [CFG_W-1:0] RESET_CFG_DEFAULT = 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_APPLY  = 2'd2,
    ST_SETTLE = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    ERR_OK      = 2'b00,
    ERR_ILLEGAL = 2'b01,
    ERR_TIMEOUT = 2'b10
  } err_e;

  typedef struct packed {
    logic       x1_local;
    logic       x0_local;
    logic       up_sel;
    logic       low_sel;
    logic [1:0] x1_sel;
    logic [1:0] x0_sel;
  } fwd_cfg_t;

endpackage

// File: rtl/forward_cfg_check.sv
// Combinational legality check of a requested forwarding config byte.
// New illegal-config rules are added here.
module forward_cfg_check
  import forward_addr_pkg::*;
(
  input  logic [CFG_W-1:0] cfg,
  output err_e             err_c
);

  fwd_cfg_t f;
  logic     unused_fields;

  assign f = fwd_cfg_t'(cfg);
  assign unused_fields = ^{f.x1_local, f.x0_local, f.x1_sel, f.x0_sel};

  // Up and low forwarding at the same time closes a loop in the address chain
  always_comb begin
    err_c = ERR_OK;
    if (f.up_sel && f.low_sel) begin
      err_c = ERR_ILLEGAL;
    end
  end

endmodule

// File: rtl/forward_addr_cfg_ctrl.sv
// Sequences forwarding-config updates for one tile: freeze new RAM issue,
// drain in-flight accesses, apply atomically, hold a settle window, release.
module forward_addr_cfg_ctrl
  import forward_addr_pkg::*;
#(
  parameter logic [CFG_W-1:0] RESET_CFG     = RESET_CFG_DEFAULT,
  parameter int unsigned      SETTLE_CYCLES = 2,
  parameter int unsigned      DRAIN_TIMEOUT = 255
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             cfg_req_i,
  input  logic [CFG_W-1:0] cfg_data_i,
  input  logic             ram_en_x0_i,
  input  logic             ram_en_x1_i,
  output logic [CFG_W-1:0] cfg_forward_addr_o,
  output logic             cfg_busy_o,
  output logic             cfg_ack_o,
  output logic [1:0]       cfg_err_o,
  output logic             cfg_overrun_o,
  output logic             freeze_o
);

  localparam logic [DRAIN_CNT_W-1:0]  DRAIN_LIMIT = DRAIN_CNT_W'(DRAIN_TIMEOUT);
  localparam logic [SETTLE_CNT_W-1:0] SETTLE_LOAD = SETTLE_CNT_W'(SETTLE_CYCLES - 1);

  state_e                  state_q, state_d;
  logic [CFG_W-1:0]        shadow_q, shadow_d;
  logic [CFG_W-1:0]        cfg_q, cfg_d;
  logic [DRAIN_CNT_W-1:0]  drain_cnt_q, drain_cnt_d;
  logic [SETTLE_CNT_W-1:0] settle_cnt_q, settle_cnt_d;
  err_e                    pend_err_q, pend_err_d;
  err_e                    err_q, err_d;
  err_e                    chk_err_c;
  logic                    ack_q, ack_d;
  logic                    overrun_q, overrun_d;
  logic                    busy_q, freeze_q;
  logic                    ram_busy_c;

  assign ram_busy_c = ram_en_x0_i | ram_en_x1_i;

  forward_cfg_check u_check (
    .cfg   (cfg_data_i),
    .err_c (chk_err_c)
  );

  // Next-state and next-output logic
  always_comb begin
    state_d      = state_q;
    shadow_d     = shadow_q;
    cfg_d        = cfg_q;
    drain_cnt_d  = drain_cnt_q;
    settle_cnt_d = settle_cnt_q;
    pend_err_d   = ERR_OK;
    err_d        = ERR_OK;
    ack_d        = 1'b0;
    overrun_d    = overrun_q;

    if (cfg_req_i && (state_q != ST_IDLE)) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        // A rejected request is acknowledged one cycle after capture
        if (pend_err_q != ERR_OK) begin
          ack_d = 1'b1;
          err_d = pend_err_q;
        end
        if (cfg_req_i) begin
          shadow_d = cfg_data_i;
          if (chk_err_c != ERR_OK) begin
            pend_err_d = chk_err_c;
          end else begin
            state_d     = ST_DRAIN;
            drain_cnt_d = '0;
          end
        end
      end
      ST_DRAIN: begin
        if (!ram_busy_c) begin
          state_d = ST_APPLY;
        end else if (drain_cnt_q == DRAIN_LIMIT) begin
          state_d = ST_IDLE;
          ack_d   = 1'b1;
          err_d   = ERR_TIMEOUT;
        end else begin
          drain_cnt_d = drain_cnt_q + DRAIN_CNT_W'(1);
        end
      end
      ST_APPLY: begin
        cfg_d        = shadow_q;
        settle_cnt_d = SETTLE_LOAD;
        state_d      = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (settle_cnt_q == '0) begin
          state_d = ST_IDLE;
          ack_d   = 1'b1;
          err_d   = ERR_OK;
        end else begin
          settle_cnt_d = settle_cnt_q - SETTLE_CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; freeze covers DRAIN, APPLY and SETTLE
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= ST_IDLE;
      shadow_q     <= RESET_CFG;
      cfg_q        <= RESET_CFG;
      drain_cnt_q  <= '0;
      settle_cnt_q <= '0;
      pend_err_q   <= ERR_OK;
      err_q        <= ERR_OK;
      ack_q        <= 1'b0;
      overrun_q    <= 1'b0;
      busy_q       <= 1'b0;
      freeze_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      shadow_q     <= shadow_d;
      cfg_q        <= cfg_d;
      drain_cnt_q  <= drain_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      pend_err_q   <= pend_err_d;
      err_q        <= err_d;
      ack_q        <= ack_d;
      overrun_q    <= overrun_d;
      busy_q       <= (state_d != ST_IDLE);
      freeze_q     <= (state_d != ST_IDLE);
    end
  end

  assign cfg_forward_addr_o = cfg_q;
  assign cfg_busy_o         = busy_q;
  assign cfg_ack_o          = ack_q;
  assign cfg_err_o          = err_q;
  assign cfg_overrun_o      = overrun_q;
  assign freeze_o           = freeze_q;

endmodule

// File: tb/tb_forward_addr_cfg_ctrl.sv
// Bench for forward_addr_cfg_ctrl: two instances (default timing, short drain
// timeout) checked every cycle against an edge-scheduled behavioural model.
module tb_forward_addr_cfg_ctrl;

  localparam int unsigned N     = 2;
  localparam int unsigned SET_A = 2;
  localparam int unsigned TO_A  = 255;
  localparam int unsigned SET_B = 3;
  localparam int unsigned TO_B  = 4;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       req  [N];
  logic [7:0] data [N];
  logic       x0   [N];
  logic       x1   [N];
  logic [7:0] cfg_o  [N];
  logic       busy_o [N];
  logic       ack_o  [N];
  logic [1:0] err_o  [N];
  logic       ovr_o  [N];
  logic       frz_o  [N];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  forward_addr_cfg_ctrl #(.SETTLE_CYCLES(SET_A), .DRAIN_TIMEOUT(TO_A)) dut_a (
    .clk_i(clk), .rst_n_i(rst_n), .cfg_req_i(req[0]), .cfg_data_i(data[0]),
    .ram_en_x0_i(x0[0]), .ram_en_x1_i(x1[0]),
    .cfg_forward_addr_o(cfg_o[0]), .cfg_busy_o(busy_o[0]), .cfg_ack_o(ack_o[0]),
    .cfg_err_o(err_o[0]), .cfg_overrun_o(ovr_o[0]), .freeze_o(frz_o[0]));

  forward_addr_cfg_ctrl #(.SETTLE_CYCLES(SET_B), .DRAIN_TIMEOUT(TO_B)) dut_b (
    .clk_i(clk), .rst_n_i(rst_n), .cfg_req_i(req[1]), .cfg_data_i(data[1]),
    .ram_en_x0_i(x0[1]), .ram_en_x1_i(x1[1]),
    .cfg_forward_addr_o(cfg_o[1]), .cfg_busy_o(busy_o[1]), .cfg_ack_o(ack_o[1]),
    .cfg_err_o(err_o[1]), .cfg_overrun_o(ovr_o[1]), .freeze_o(frz_o[1]));

  // Model: on acceptance the controller is busy until an absolute ack edge,
  // computed once the RAM has been seen idle (or the wait budget runs out).
  typedef struct {
    logic       busy;
    logic       draining;
    int         waited;
    longint     apply_e;
    longint     done_e;
    longint     ill_e;
    logic [7:0] cfg;
    logic [7:0] shadow;
    logic       ovr;
    logic       ack;
    logic [1:0] err;
  } mdl_t;

  mdl_t        m [N];
  longint      edge_n = 0;
  int unsigned settle_p [N];
  int unsigned timeout_p [N];
  int          stuck [N];

  task automatic mreset(input int i);
    m[i].busy = 1'b0; m[i].draining = 1'b0; m[i].waited = 0;
    m[i].apply_e = -1; m[i].done_e = -1; m[i].ill_e = -1;
    m[i].cfg = 8'h00; m[i].shadow = 8'h00; m[i].ovr = 1'b0;
    m[i].ack = 1'b0; m[i].err = 2'b00;
  endtask

  task automatic mstep(input int i);
    logic was_busy;
    was_busy = m[i].busy;
    m[i].ack = 1'b0;
    if (was_busy) begin
      if (req[i]) m[i].ovr = 1'b1;
      if (m[i].draining) begin
        if (!(x0[i] || x1[i])) begin
          m[i].draining = 1'b0;
          m[i].apply_e  = edge_n + 1;
          m[i].done_e   = edge_n + 1 + longint'(settle_p[i]);
        end else if (m[i].waited == int'(timeout_p[i])) begin
          m[i].draining = 1'b0; m[i].busy = 1'b0;
          m[i].ack = 1'b1; m[i].err = 2'b10;
        end else begin
          m[i].waited++;
        end
      end else begin
        if (edge_n == m[i].apply_e) m[i].cfg = m[i].shadow;
        if (edge_n == m[i].done_e) begin
          m[i].busy = 1'b0; m[i].ack = 1'b1; m[i].err = 2'b00;
        end
      end
    end else begin
      if (edge_n == m[i].ill_e) begin
        m[i].ack = 1'b1; m[i].err = 2'b01;
      end
      if (req[i]) begin
        m[i].shadow = data[i];
        if (data[i][5:4] == 2'b11) m[i].ill_e = edge_n + 1;
        else begin
          m[i].busy = 1'b1; m[i].draining = 1'b1; m[i].waited = 0;
        end
      end
    end
  endtask

  initial begin
    settle_p[0] = SET_A; settle_p[1] = SET_B;
    timeout_p[0] = TO_A; timeout_p[1] = TO_B;
    mreset(0); mreset(1);
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mreset(0); mreset(1);
      end else begin
        mstep(0); mstep(1);
      end
      edge_n++;
    end
  end

  task automatic chk(input string name, input int i, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[%0d] t=%0t got %h expected %h", name, i, $time, act, exp);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < int'(N); i++) begin
        chk("cfg", i, cfg_o[i], m[i].cfg);
        chk("busy", i, 8'(busy_o[i]), 8'(m[i].busy));
        chk("freeze", i, 8'(frz_o[i]), 8'(m[i].busy));
        chk("ack", i, 8'(ack_o[i]), 8'(m[i].ack));
        chk("overrun", i, 8'(ovr_o[i]), 8'(m[i].ovr));
        if (m[i].ack) chk("err", i, 8'(err_o[i]), 8'(m[i].err));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_req(input int i, input logic [7:0] d);
    req[i] = 1'b1; data[i] = d;
    tick();
    req[i] = 1'b0;
  endtask

  task automatic wait_ack(input int i, input int bound, output int lat);
    lat = 0;
    while (!ack_o[i] && lat < bound) begin
      tick();
      lat++;
    end
    if (!ack_o[i]) begin
      tests++; fails++;
      $display("FAIL ack_wait[%0d] no ack within %0d cycles", i, bound);
    end
  endtask

  int lat;
  int frz_cnt;

  initial begin
    for (int i = 0; i < int'(N); i++) begin
      req[i] = 1'b0; data[i] = 8'h00; x0[i] = 1'b0; x1[i] = 1'b0; stuck[i] = 0;
    end
    repeat (3) tick();
    for (int i = 0; i < int'(N); i++) begin
      chk("rst_cfg", i, cfg_o[i], 8'h00);
      chk("rst_freeze", i, 8'(frz_o[i]), 8'h00);
      chk("rst_busy", i, 8'(busy_o[i]), 8'h00);
      chk("rst_ack", i, 8'(ack_o[i]), 8'h00);
    end
    rst_n = 1'b1;
    tick();

    // Legal request, RAM idle
    pulse_req(0, 8'h5A);
    chk("5a_busy_e0", 0, 8'(busy_o[0]), 8'h01);
    frz_cnt = frz_o[0] ? 1 : 0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k < 4 && frz_o[0]) frz_cnt++;
      if (k == 2) chk("5a_cfg_e2", 0, cfg_o[0], 8'h5A);
      if (k == 3) chk("5a_ack_e3", 0, 8'(ack_o[0]), 8'h00);
    end
    chk("5a_ack_e4", 0, 8'(ack_o[0]), 8'h01);
    chk("5a_err_e4", 0, 8'(err_o[0]), 8'h00);
    chk("5a_freeze_e4", 0, 8'(frz_o[0]), 8'h00);
    chk("5a_freeze_len", 0, 8'(frz_cnt), 8'd4);
    tick();

    // x0 busy for six edges after the request
    x0[0] = 1'b1;
    pulse_req(0, 8'h0F);
    repeat (6) tick();
    chk("0f_cfg_held", 0, cfg_o[0], 8'h5A);
    x0[0] = 1'b0;
    wait_ack(0, 50, lat);
    chk("0f_ack_edge", 0, 8'(6 + lat), 8'd10);
    chk("0f_cfg", 0, cfg_o[0], 8'h0F);
    tick();

    // Illegal up/low loop
    pulse_req(0, 8'h30);
    chk("30_freeze_e0", 0, 8'(frz_o[0]), 8'h00);
    tick();
    chk("30_ack_e1", 0, 8'(ack_o[0]), 8'h01);
    chk("30_err_e1", 0, 8'(err_o[0]), 8'h01);
    chk("30_cfg", 0, cfg_o[0], 8'h0F);
    tick();

    // Drain timeout on the short-timeout instance
    x1[1] = 1'b1;
    pulse_req(1, 8'h05);
    wait_ack(1, 50, lat);
    chk("to_ack_edge", 1, 8'(lat), 8'd5);
    chk("to_err", 1, 8'(err_o[1]), 8'h02);
    chk("to_cfg", 1, cfg_o[1], 8'h00);
    chk("to_freeze", 1, 8'(frz_o[1]), 8'h00);
    x1[1] = 1'b0;
    tick();

    // Second request during SETTLE
    pulse_req(0, 8'hA1);
    tick(); tick();
    pulse_req(0, 8'h42);
    chk("ovr_set", 0, 8'(ovr_o[0]), 8'h01);
    wait_ack(0, 20, lat);
    chk("ovr_cfg", 0, cfg_o[0], 8'hA1);
    tick();

    // Reset during DRAIN
    x0[0] = 1'b1;
    pulse_req(0, 8'h47);
    tick();
    rst_n = 1'b0;
    #1;
    chk("rd_cfg", 0, cfg_o[0], 8'h00);
    chk("rd_busy", 0, 8'(busy_o[0]), 8'h00);
    chk("rd_freeze", 0, 8'(frz_o[0]), 8'h00);
    chk("rd_overrun", 0, 8'(ovr_o[0]), 8'h00);
    x0[0] = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Randomized traffic, checked by the per-cycle compare process
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < int'(N); i++) begin
        req[i]  = ($urandom_range(0, 5) == 0);
        data[i] = 8'($urandom);
        if ($urandom_range(0, 3) == 0) data[i][5:4] = 2'b11;
        if (stuck[i] > 0) begin
          x0[i] = 1'b1;
          stuck[i]--;
        end else begin
          x0[i] = ($urandom_range(0, 2) == 0);
          x1[i] = ($urandom_range(0, 3) == 0);
          if ($urandom_range(0, 40) == 0) stuck[i] = int'($urandom_range(3, 12));
        end
      end
      if (c == 1500) rst_n = 1'b0;
      if (c == 1502) rst_n = 1'b1;
      tick();
    end
    for (int i = 0; i < int'(N); i++) begin
      req[i] = 1'b0; x0[i] = 1'b0; x1[i] = 1'b0;
    end
    repeat (20) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
